sobel_seq_ctrl: RTL and testbench

Parametrised sequencer for the Sobel datapath: it walks a WIDTH×HEIGHT frame as a three-row sliding window over a Wishbone-style single-transfer bus. For each word column it reads the prev, curr and next row words, runs a configurable number of compute/shift cycles, and writes one result word. It drives the row-load strobes, shift enable and address-offset counter enables of the datapath and address generator. Over the previous fixed 640×480 / 4-cycle controller it adds configurable pixels-per-word, compute depth and frame size, a `busy` status, an `abort` input and an ack-timeout error.

---
 rtl/sobel_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sobel_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_seq_ctrl.sv
// Sobel window sequencer: walks a WIDTH x HEIGHT frame as a three-row window over a
// single-transfer bus, pacing row loads, compute shifts and one result write per column.
module sobel_seq_ctrl #(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned COMP_CYCLES  = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic                                      ack_i,
    output logic                                      cyc_o,
    output logic                                      stb_o,
    output logic                                      we_o,
    output logic                                      offset_reset,
    output logic                                      o_offset_cnt_en,
    output logic                                      d_offset_cnt_en,
    output logic                                      prev_row_load,
    output logic                                      curr_row_load,
    output logic                                      next_row_load,
    output logic                                      shift_en,
    output logic                                      busy,
    output logic                                      done_set,
    output logic                                      timeout_err,
    output logic [$clog2(HEIGHT)-1:0]                 row_o,
    output logic [$clog2(WIDTH/PIX_PER_WORD+1)-1:0]   col_o
);

    localparam int unsigned COLS = WIDTH / PIX_PER_WORD;
    localparam int unsigned RW   = $clog2(HEIGHT);
    localparam int unsigned CW   = $clog2(COLS + 1);
    localparam int unsigned KW   = $clog2(COMP_CYCLES + 1);
    localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 3);
    localparam logic [CW-1:0] COLS_L    = CW'(COLS);
    localparam logic [KW-1:0] COMP_LAST = KW'(COMP_CYCLES - 1);
    localparam logic [TW-1:0] WD_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PREV,
        S_RD_CURR,
        S_RD_NEXT,
        S_COMP,
        S_WR,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [CW-1:0] wr_q, wr_d;
    logic [KW-1:0] comp_q, comp_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          bus_st;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            comp_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            comp_q  <= comp_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        rd_d            = rd_q;
        wr_d            = wr_q;
        comp_d          = comp_q;
        wd_d            = wd_q;
        cyc_o           = 1'b0;
        we_o            = 1'b0;
        offset_reset    = 1'b0;
        o_offset_cnt_en = 1'b0;
        d_offset_cnt_en = 1'b0;
        prev_row_load   = 1'b0;
        curr_row_load   = 1'b0;
        next_row_load   = 1'b0;
        shift_en        = 1'b0;
        done_set        = 1'b0;
        timeout_err     = 1'b0;
        bus_st          = 1'b0;

        case (state_q)
            S_IDLE: begin
                offset_reset = 1'b1;
                if (start) begin
                    row_d   = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = abort ? S_IDLE : S_RD_PREV;
                end
            end
            S_RD_PREV: begin
                cyc_o         = 1'b1;
                prev_row_load = 1'b1;
                bus_st        = 1'b1;
                if (ack_i) state_d = S_RD_CURR;
            end
            S_RD_CURR: begin
                cyc_o         = 1'b1;
                curr_row_load = 1'b1;
                bus_st        = 1'b1;
                if (ack_i) state_d = S_RD_NEXT;
            end
            S_RD_NEXT: begin
                cyc_o         = 1'b1;
                next_row_load = 1'b1;
                bus_st        = 1'b1;
                if (ack_i) begin
                    o_offset_cnt_en = 1'b1;
                    rd_d            = rd_q + 1'b1;
                    state_d         = S_COMP;
                end
            end
            S_COMP: begin
                shift_en = 1'b1;
                if (comp_q == COMP_LAST) begin
                    // first column of a row only primes the window; nothing to write yet
                    state_d = (rd_q == CW'(1) && wr_q == '0) ? S_RD_PREV : S_WR;
                end else begin
                    comp_d = comp_q + 1'b1;
                end
            end
            S_WR: begin
                cyc_o  = 1'b1;
                we_o   = 1'b1;
                bus_st = 1'b1;
                if (ack_i) begin
                    d_offset_cnt_en = 1'b1;
                    wr_d            = wr_q + 1'b1;
                    if (wr_q + 1'b1 == COLS_L) begin
                        if (row_q == ROW_LAST) begin
                            done_set = !abort;
                            state_d  = S_IDLE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            rd_d    = '0;
                            wr_d    = '0;
                            state_d = S_RD_PREV;
                        end
                    end else if (rd_q == COLS_L) begin
                        state_d = S_COMP;
                    end else begin
                        state_d = S_RD_PREV;
                    end
                end
            end
            S_ERR: begin
                timeout_err = 1'b1;
                if (start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus_st && !ack_i) begin
            if (TIMEOUT != 0 && wd_q == WD_LAST) state_d = S_ERR;
            else                                 wd_d    = wd_q + 1'b1;
        end

        // abort overrides everything except the completion of an acked transfer
        if (abort && state_q != S_IDLE && state_q != S_ERR) state_d = S_IDLE;

        if (ack_i || state_d != state_q) wd_d = '0;
        if (state_d != S_COMP) comp_d = '0;
    end

    assign stb_o = cyc_o;
    assign busy  = (state_q != S_IDLE) && (state_q != S_ERR);
    assign row_o = row_q;
    assign col_o = rd_q;

endmodule

// File: tb/tb_sobel_seq_ctrl.sv
// Bench for sobel_seq_ctrl: a transfer-list reference model built from the frame
// geometry is stepped alongside the DUT under randomized ack, start and abort.
module tb_sobel_seq_ctrl;

    localparam int unsigned W_A = 16, H_A = 5, P_A = 4, K_A = 4, T_A = 8;
    localparam int unsigned COLS_A = W_A / P_A;
    localparam int unsigned W_B = 8, H_B = 4, P_B = 4, K_B = 1, T_B = 0;

    // op codes of the reference transfer list
    localparam int unsigned OP_RP = 0, OP_RC = 1, OP_RN = 2, OP_C = 3, OP_W = 4, OP_WROW = 5, OP_WEND = 6;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni, start, abort, ack_i;
    logic cyc_o, stb_o, we_o, offset_reset, o_offset_cnt_en, d_offset_cnt_en;
    logic prev_row_load, curr_row_load, next_row_load, shift_en, busy, done_set, timeout_err;
    logic [$clog2(H_A)-1:0]        row_o;
    logic [$clog2(COLS_A+1)-1:0]   col_o;

    logic b_start, b_abort, b_ack;
    logic b_cyc_o, b_stb_o, b_we_o, b_orst, b_oen, b_den, b_pl, b_cl, b_nl, b_shift_en, b_busy, b_done_set, b_terr;
    logic [$clog2(H_B)-1:0]        b_row_o;
    logic [$clog2(W_B/P_B+1)-1:0]  b_col_o;

    sobel_seq_ctrl #(.WIDTH(W_A), .HEIGHT(H_A), .PIX_PER_WORD(P_A), .COMP_CYCLES(K_A), .TIMEOUT(T_A)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start(start), .abort(abort), .ack_i(ack_i),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .offset_reset(offset_reset),
        .o_offset_cnt_en(o_offset_cnt_en), .d_offset_cnt_en(d_offset_cnt_en),
        .prev_row_load(prev_row_load), .curr_row_load(curr_row_load), .next_row_load(next_row_load),
        .shift_en(shift_en), .busy(busy), .done_set(done_set), .timeout_err(timeout_err),
        .row_o(row_o), .col_o(col_o)
    );

    sobel_seq_ctrl #(.WIDTH(W_B), .HEIGHT(H_B), .PIX_PER_WORD(P_B), .COMP_CYCLES(K_B), .TIMEOUT(T_B)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start(b_start), .abort(b_abort), .ack_i(b_ack),
        .cyc_o(b_cyc_o), .stb_o(b_stb_o), .we_o(b_we_o), .offset_reset(b_orst),
        .o_offset_cnt_en(b_oen), .d_offset_cnt_en(b_den),
        .prev_row_load(b_pl), .curr_row_load(b_cl), .next_row_load(b_nl),
        .shift_en(b_shift_en), .busy(b_busy), .done_set(b_done_set), .timeout_err(b_terr),
        .row_o(b_row_o), .col_o(b_col_o)
    );

    logic [12:0] outs;
    assign outs = {cyc_o, stb_o, we_o, offset_reset, o_offset_cnt_en, d_offset_cnt_en,
                   prev_row_load, curr_row_load, next_row_load, shift_en, busy, done_set, timeout_err};

    int unsigned n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: remaining transfers of the frame, plus idle/error flags
    int unsigned ops[$];
    bit          m_idle = 1'b1, m_err = 1'b0;
    int unsigned m_comp_left, m_wait, m_row, m_col;

    // per-frame observations
    int unsigned f_reads, f_writes, f_oen, f_den, f_done, f_done_cyc, f_cyc, f_hold_cyc;

    task automatic build_frame();
        ops.delete();
        for (int r = 0; r < int'(H_A) - 2; r++) begin
            for (int c = 0; c < int'(COLS_A); c++) begin
                ops.push_back(OP_RP); ops.push_back(OP_RC); ops.push_back(OP_RN); ops.push_back(OP_C);
                if (c > 0) ops.push_back(OP_W);
            end
            ops.push_back(OP_C);
            ops.push_back((r == int'(H_A) - 3) ? OP_WEND : OP_WROW);
        end
    endtask

    function automatic logic [12:0] exp_outs(input bit ab, input bit ak);
        bit cy = 0, we = 0, orst = 0, oen = 0, den = 0, pl = 0, cl = 0, nl = 0, sh = 0, bz = 0, dn = 0, te = 0;
        if (m_idle)     orst = 1;
        else if (m_err) te = 1;
        else begin
            bz = 1;
            case (ops[0])
                OP_RP:   begin cy = 1; pl = 1; end
                OP_RC:   begin cy = 1; cl = 1; end
                OP_RN:   begin cy = 1; nl = 1; oen = ak; end
                OP_C:    sh = 1;
                default: begin cy = 1; we = 1; den = ak; dn = ak && (ops[0] == OP_WEND) && !ab; end
            endcase
        end
        return {cy, cy, we, orst, oen, den, pl, cl, nl, sh, bz, dn, te};
    endfunction

    task automatic model_step(input bit st, input bit ab, input bit ak);
        if (m_idle) begin
            if (st) begin
                m_row = 0; m_col = 0;
                if (!ab) begin build_frame(); m_idle = 0; m_comp_left = K_A; m_wait = 0; end
            end
        end else if (m_err) begin
            if (st) begin m_err = 0; m_idle = 1; end
        end else begin
            bit fin = 0;
            bit to  = 0;
            if (ops[0] == OP_C) begin
                m_comp_left--;
                fin = (m_comp_left == 0);
            end else if (ak) begin
                fin = 1;
                if (ops[0] == OP_RN)   m_col++;
                if (ops[0] == OP_WROW) begin m_row++; m_col = 0; end
            end else begin
                m_wait++;
                to = (T_A != 0) && (m_wait == T_A);
            end
            if (fin) begin void'(ops.pop_front()); m_comp_left = K_A; m_wait = 0; end
            if (ab || ops.size() == 0) m_idle = 1;
            else if (to)               m_err  = 1;
        end
    endtask

    task automatic tick(input bit st, input bit ab, input bit ak);
        @(negedge clk_i);
        start = st; abort = ab; ack_i = ak;
        #1;
        check("outs", outs, exp_outs(ab, ak));
        check("row_o", row_o, m_row);
        check("col_o", col_o, m_col);
        if (cyc_o && !we_o && ack_i) f_reads++;
        if (cyc_o && we_o && ack_i)  f_writes++;
        if (o_offset_cnt_en) f_oen++;
        if (d_offset_cnt_en) f_den++;
        if (done_set) begin f_done++; f_done_cyc = f_cyc; end
        f_cyc++;
        model_step(st, ab, ak);
    endtask

    // mode: 0 ack high, 1 three waits, 2 random waits, 3 stall 2nd curr read,
    // 4 abort in COMP of row 1, 5 abort with ack in first write, 6 random waits + random abort
    task automatic run_frame(input int unsigned mode, input bit hold);
        int unsigned n = 0, curr_acks = 0;
        bit ak, ab, stall;
        f_reads = 0; f_writes = 0; f_oen = 0; f_den = 0; f_done = 0; f_done_cyc = 0; f_cyc = 0; f_hold_cyc = 0;
        tick(1'b1, 1'b0, 1'b0);
        while (!m_idle && !m_err && n < 3000) begin
            ab = 0; stall = 0;
            case (mode)
                0: ak = 1;
                1: ak = (m_wait == 3);
                3: begin stall = (ops[0] == OP_RC && curr_acks == 1); ak = !stall; end
                4: begin ak = 1; ab = (m_row == 1 && ops[0] == OP_C); end
                5: begin ak = 1; ab = (ops[0] >= OP_W); end
                default: begin
                    ak = ($urandom_range(0, 2) == 0) || (m_wait >= 4);
                    ab = (mode == 6) && ($urandom_range(0, 149) == 0);
                end
            endcase
            if (ops[0] == OP_RC && ak) curr_acks++;
            tick(hold, ab, ak);
            if (stall && cyc_o) f_hold_cyc++;
            n++;
        end
        tick(1'b0, 1'b0, 1'b0);
        check("idle_after", busy, 1'b0);
    endtask

    int unsigned tot_oen, tot_den, n_wait, b_writes, b_done, b_done_cyc;
    int unsigned b_shift[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_ni = 1'b0; start = 1'b0; abort = 1'b0; ack_i = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_ack = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_outs", outs, 13'h200);
        check("rst_row", row_o, 0);
        check("rst_col", col_o, 0);
        check("b_rst_orst_busy", {b_orst, b_busy, b_cyc_o}, 3'b100);
        rst_ni = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // second configuration: two words per row, single compute cycle
        @(negedge clk_i); b_start = 1'b1; #1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i); b_start = 1'b0; #1;
            if (b_shift_en) b_shift[b_row_o]++;
            if (b_cyc_o && b_we_o) b_writes++;
            if (b_done_set) begin b_done++; b_done_cyc = c; end
        end
        check("b_shift_row0", b_shift[0], 3);
        check("b_shift_row1", b_shift[1], 3);
        check("b_writes", b_writes, 4);
        check("b_done_cnt", b_done, 1);
        check("b_done_cyc", b_done_cyc, 22);
        check("b_busy_end", b_busy, 1'b0);

        run_frame(0, 1'b0);
        check("a0_reads", f_reads, 36);
        check("a0_writes", f_writes, 12);
        check("a0_done_cnt", f_done, 1);
        check("a0_done_cyc", f_done_cyc, 108);

        run_frame(0, 1'b1);
        check("hold_done_cnt", f_done, 1);
        check("hold_done_cyc", f_done_cyc, 108);

        tot_oen = 0; tot_den = 0;
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 1'b0);
            tot_oen += f_oen; tot_den += f_den;
            check("w3_oen", f_oen, 12);
            check("w3_den", f_den, 12);
            check("w3_done_cyc", f_done_cyc, 252);
        end
        check("w3_tot_oen", tot_oen, 48);
        check("w3_tot_den", tot_den, 48);

        run_frame(3, 1'b0);
        check("to_cyc_cycles", f_hold_cyc, 8);
        check("to_err", timeout_err, 1'b1);
        check("to_oen", f_oen, 1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("to_clear_orst", offset_reset, 1'b1);
        check("to_clear_err", timeout_err, 1'b0);

        run_frame(4, 1'b0);
        check("ab_comp_done", f_done, 0);
        run_frame(5, 1'b0);
        check("ab_wr_den", f_den, 1);
        check("ab_wr_writes", f_writes, 1);
        check("ab_wr_done", f_done, 0);

        for (int i = 0; i < 3; i++) begin
            run_frame(2, 1'($urandom_range(0, 1)));
            check("rnd_reads", f_reads, 36);
            check("rnd_writes", f_writes, 12);
            check("rnd_done", f_done, 1);
        end
        for (int i = 0; i < 4; i++) run_frame(6, 1'b0);

        // reset in the middle of the first write of row 1
        tick(1'b1, 1'b0, 1'b0);
        n_wait = 0;
        while (!m_idle && !(ops[0] >= OP_W && m_row == 1) && n_wait < 1000) begin
            tick(1'b0, 1'b0, 1'b1);
            n_wait++;
        end
        @(negedge clk_i); start = 1'b0; abort = 1'b0; ack_i = 1'b1;
        #1;
        check("pre_rst_wr", {cyc_o, we_o, row_o}, {2'b11, 3'd1});
        rst_ni = 1'b0;
        #1;
        check("rst_cyc_we_den", {cyc_o, we_o, d_offset_cnt_en}, 3'b000);
        check("rst_mid_outs", outs, 13'h200);
        @(negedge clk_i); rst_ni = 1'b1; ack_i = 1'b0;
        m_idle = 1; m_err = 0; m_row = 0; m_col = 0;
        #1;
        check("rst_row_after", row_o, 0);
        tick(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
